// File: rtl/bo_bias_add.sv
// Two-stage bias add with per-lane saturation for accumulator beats.
// A group counter walks the bias buffer one word per accepted beat.
module bo_bias_add #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int ACC_WL    = 32,
  parameter int GROUPS    = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        grp_clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UNITS_NUM*ACC_WL-1:0] in_acc,
  output logic [7:0]                  bias_addr,
  input  logic [UNITS_NUM*D_WL-1:0]   bias_w,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UNITS_NUM*D_WL-1:0]   out_data,
  output logic                        out_last,
  output logic                        sat_any
);

  localparam int GRP_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int SUM_W = ACC_WL + 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-D_WL+1){1'b0}}, {(D_WL-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-D_WL+1){1'b1}}, {(D_WL-1){1'b0}}};

  function automatic logic signed [SUM_W-1:0] sext_acc(input logic [ACC_WL-1:0] a);
    return {a[ACC_WL-1], a};
  endfunction

  function automatic logic signed [SUM_W-1:0] sext_bias(input logic [D_WL-1:0] b);
    return {{(SUM_W-D_WL){b[D_WL-1]}}, b};
  endfunction

  function automatic logic clamps(input logic signed [SUM_W-1:0] s);
    return (s > SAT_MAX) || (s < SAT_MIN);
  endfunction

  function automatic logic [D_WL-1:0] saturate(input logic signed [SUM_W-1:0] s);
    if (s > SAT_MAX) begin
      return SAT_MAX[D_WL-1:0];
    end else if (s < SAT_MIN) begin
      return SAT_MIN[D_WL-1:0];
    end else begin
      return s[D_WL-1:0];
    end
  endfunction

  logic [GRP_W-1:0]        r_grp;
  logic                    w_adv;
  logic                    w_accept;
  logic                    w_clamp_any;
  logic signed [SUM_W-1:0] w_sum [UNITS_NUM];
  logic [D_WL-1:0]         w_sat [UNITS_NUM];

  logic                    r_vld_p1;
  logic                    r_last_p1;
  logic signed [SUM_W-1:0] r_sum_p1 [UNITS_NUM];

  logic                    r_vld_p2;
  logic                    r_last_p2;
  logic [UNITS_NUM*D_WL-1:0] r_data_p2;
  logic                    r_sat_any;

  // The whole pipeline moves together; a stalled output freezes both stages.
  assign w_adv    = !r_vld_p2 || out_ready;
  assign in_ready = rst_n && w_adv;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    bias_addr = '0;
    bias_addr[GRP_W-1:0] = r_grp;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grp <= '0;
    end else if (grp_clr) begin
      r_grp <= '0;
    end else if (w_accept) begin
      r_grp <= (r_grp == GRP_LAST) ? '0 : r_grp + 1'b1;
    end
  end

  // Stage p1: widened sum of accumulator and bias lanes
  always_comb begin
    for (int k = 0; k < UNITS_NUM; k++) begin
      w_sum[k] = sext_acc(in_acc[k*ACC_WL +: ACC_WL]) + sext_bias(bias_w[k*D_WL +: D_WL]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      for (int k = 0; k < UNITS_NUM; k++) begin
        r_sum_p1[k] <= '0;
      end
    end else if (w_adv) begin
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_last_p1 <= (r_grp == GRP_LAST);
        for (int k = 0; k < UNITS_NUM; k++) begin
          r_sum_p1[k] <= w_sum[k];
        end
      end
    end
  end

  // Stage p2: saturate to output lane width
  always_comb begin
    w_clamp_any = 1'b0;
    for (int k = 0; k < UNITS_NUM; k++) begin
      w_sat[k]    = saturate(r_sum_p1[k]);
      w_clamp_any = w_clamp_any | clamps(r_sum_p1[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_p2  <= 1'b0;
      r_last_p2 <= 1'b0;
      r_data_p2 <= '0;
    end else if (w_adv) begin
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
      for (int k = 0; k < UNITS_NUM; k++) begin
        r_data_p2[k*D_WL +: D_WL] <= w_sat[k];
      end
    end
  end

  // Sticky saturation flag; a clamp on the same edge as grp_clr keeps it set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sat_any <= 1'b0;
    end else if (w_adv && r_vld_p1 && w_clamp_any) begin
      r_sat_any <= 1'b1;
    end else if (grp_clr) begin
      r_sat_any <= 1'b0;
    end
  end

  assign out_valid = r_vld_p2;
  assign out_last  = r_last_p2;
  assign out_data  = r_data_p2;
  assign sat_any   = r_sat_any;

endmodule
